// File: rtl/usb2_pkg.sv
// usb2_pkg: shared USB 2.0 definitions for the device-side protocol blocks.
// Holds the 4-bit PID codes exchanged with the protocol layer, the maximum
// high-speed bulk packet size, and the endpoint sequencer state type.
package usb2_pkg;

  // PID nibbles as presented on xfer_pid / data_pid by the protocol layer.
  localparam logic [3:0] PID_DATA_0   = 4'hC;
  localparam logic [3:0] PID_DATA_1   = 4'h4;
  localparam logic [3:0] PID_HAND_ACK = 4'hD;
  // No handshake seen by the protocol layer (host timeout).
  localparam logic [3:0] PID_NONE     = 4'h0;

  localparam int USB2_MAX_PKT = 512;

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_IDLE      = 2'd1,
    ST_IN_ACTIVE = 2'd2,
    ST_IN_DONE   = 2'd3
  } ep_state_t;

  // Flip between DATA0 and DATA1.
  function automatic logic [3:0] pid_toggle(input logic [3:0] pid);
    return (pid == PID_DATA_0) ? PID_DATA_1 : PID_DATA_0;
  endfunction

endpackage

// File: rtl/usb2_ep1_in_ram.sv
// usb2_ep1_in_ram: simple dual-port packet RAM for endpoint 1 IN.
// Ports:
//   clk                         - phy_clk
//   reset                       - synchronous active-high, clears the read register only
//   wr_en / wr_addr / wr_data   - application-side write port
//   rd_addr / rd_data           - protocol-side read port, 1-cycle registered latency
module usb2_ep1_in_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  // Application write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered protocol read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/usb2_ep1_in.sv
// usb2_ep1_in: USB 2.0 endpoint 1 IN packet buffer and sequencer.
// The application writes a packet into the buffer and commits it with a
// length; on an IN token the protocol layer is told whether a packet is
// ready (else NAK) and which DATAx PID to use. The buffer is released and the
// toggle advanced only when the host ACKs.
// Build option: define USB2_EP1_IN_DOUBLEBUF_EN for two ping-pong slots
// (read in commit order); otherwise a single slot is used.
// Ports:
//   phy_clk, reset                      - clock, synchronous active-high reset
//   xfer_in                             - host OUT/SETUP to this EP (unsupported)
//   xfer_out, xfer_pid                  - IN transaction window, host handshake
//   xfer_ready, data_pid                - packet available / DATAx PID to send
//   buf_out_addr, buf_out_q, buf_out_len - protocol read side
//   app_wr_addr/data/en                 - application write port
//   app_commit, app_commit_len          - commit pulse and packet length
//   app_buf_free                        - a slot may be written and committed
//   toggle_clear                        - force DATA0
//   dbg                                 - high while in ST_IN_ACTIVE
module usb2_ep1_in import usb2_pkg::*; #(
  parameter int MAX_PKT = USB2_MAX_PKT
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic        xfer_in,
  input  logic        xfer_out,
  input  logic [3:0]  xfer_pid,
  output logic        xfer_ready,
  output logic [3:0]  data_pid,
  input  logic [8:0]  buf_out_addr,
  output logic [7:0]  buf_out_q,
  output logic [9:0]  buf_out_len,
  input  logic [8:0]  app_wr_addr,
  input  logic [7:0]  app_wr_data,
  input  logic        app_wr_en,
  input  logic        app_commit,
  input  logic [9:0]  app_commit_len,
  output logic        app_buf_free,
  input  logic        toggle_clear,
  output logic        dbg
);

  ep_state_t   state_r;
  logic        xfer_out_1_r;
  logic [3:0]  pid_cap_r;
  logic [1:0]  count_r;
  logic        wr_slot_r;
  logic        rd_slot_r;
  logic [9:0]  len_r [2];

  logic        commit_ok_s;
  logic        ack_s;
  logic [9:0]  cap_len_s;
  logic [1:0]  count_next_s;
  logic        free_next_s;

  // Commit acceptance, ACK release and the resulting occupancy.
  always_comb begin
    commit_ok_s  = app_commit && app_buf_free && (state_r != ST_RST);
    ack_s        = (state_r == ST_IN_DONE) && (pid_cap_r == PID_HAND_ACK) && xfer_ready;
    cap_len_s    = (app_commit_len > 10'(MAX_PKT)) ? 10'(MAX_PKT) : app_commit_len;
    count_next_s = count_r + {1'b0, commit_ok_s} - {1'b0, ack_s};
`ifdef USB2_EP1_IN_DOUBLEBUF_EN
    free_next_s  = (count_next_s < 2'd2);
`else
    free_next_s  = (count_next_s == 2'd0);
`endif
  end

  // Sequencer FSM, slot bookkeeping and registered protocol outputs.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_r      <= ST_RST;
      xfer_out_1_r <= 1'b0;
      pid_cap_r    <= PID_NONE;
      count_r      <= 2'd0;
      wr_slot_r    <= 1'b0;
      rd_slot_r    <= 1'b0;
      len_r[0]     <= 10'd0;
      len_r[1]     <= 10'd0;
      xfer_ready   <= 1'b0;
      data_pid     <= PID_DATA_0;
      buf_out_len  <= 10'd0;
      app_buf_free <= 1'b1;
      dbg          <= 1'b0;
    end else begin
      xfer_out_1_r <= xfer_out;
      count_r      <= count_next_s;
      app_buf_free <= free_next_s;

      if (commit_ok_s) begin
        len_r[wr_slot_r] <= cap_len_s;
`ifdef USB2_EP1_IN_DOUBLEBUF_EN
        wr_slot_r <= ~wr_slot_r;
`endif
      end

      // toggle_clear wins over an ACK toggle landing in the same cycle.
      if (toggle_clear) begin
        data_pid <= PID_DATA_0;
      end else if (ack_s) begin
        data_pid <= pid_toggle(data_pid);
`ifdef USB2_EP1_IN_DOUBLEBUF_EN
        rd_slot_r <= ~rd_slot_r;
`endif
      end

      case (state_r)
        ST_RST: begin
          count_r      <= 2'd0;
          app_buf_free <= 1'b1;
          xfer_ready   <= 1'b0;
          data_pid     <= PID_DATA_0;
          buf_out_len  <= 10'd0;
          state_r      <= ST_IDLE;
        end
        ST_IDLE: begin
          if (xfer_out && !xfer_out_1_r) begin
            // Uses the pre-commit count, so a coincident commit NAKs.
            xfer_ready  <= (count_r != 2'd0);
            buf_out_len <= len_r[rd_slot_r];
            dbg         <= 1'b1;
            state_r     <= ST_IN_ACTIVE;
          end else if (xfer_in) begin
            xfer_ready <= 1'b0;
          end
        end
        ST_IN_ACTIVE: begin
          if (!xfer_out && xfer_out_1_r) begin
            pid_cap_r <= xfer_pid;
            dbg       <= 1'b0;
            state_r   <= ST_IN_DONE;
          end
        end
        ST_IN_DONE: begin
          xfer_ready <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r <= ST_RST;
        end
      endcase

      // Release of the read slot on ACK happens above via count/rd_slot.
      if (rd_slot_r && (count_r == 2'd3)) begin
        count_r <= 2'd0;
      end
    end
  end

  logic ram_wr_en_s;
  assign ram_wr_en_s = app_wr_en && app_buf_free;

`ifdef USB2_EP1_IN_DOUBLEBUF_EN
  usb2_ep1_in_ram #(.ADDR_W(10)) u_ram (
    .clk     (phy_clk),
    .reset   (reset),
    .wr_en   (ram_wr_en_s),
    .wr_addr ({wr_slot_r, app_wr_addr}),
    .wr_data (app_wr_data),
    .rd_addr ({rd_slot_r, buf_out_addr}),
    .rd_data (buf_out_q)
  );
`else
  usb2_ep1_in_ram #(.ADDR_W(9)) u_ram (
    .clk     (phy_clk),
    .reset   (reset),
    .wr_en   (ram_wr_en_s),
    .wr_addr (app_wr_addr),
    .wr_data (app_wr_data),
    .rd_addr (buf_out_addr),
    .rd_data (buf_out_q)
  );
`endif

endmodule

// File: tb/tb_usb2_ep1_in.sv
// tb_usb2_ep1_in: self-checking bench for usb2_ep1_in. IN-transaction
// expectations are queued by the stimulus and checked by a monitor when the
// DUT enters its IN window (dbg rising).
module tb_usb2_ep1_in;
  import usb2_pkg::*;

`ifdef USB2_EP1_IN_DOUBLEBUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       phy_clk = 1'b0;
  logic       reset = 1'b1;
  logic       xfer_in = 1'b0;
  logic       xfer_out = 1'b0;
  logic [3:0] xfer_pid = 4'h0;
  logic       xfer_ready;
  logic [3:0] data_pid;
  logic [8:0] buf_out_addr = 9'd0;
  logic [7:0] buf_out_q;
  logic [9:0] buf_out_len;
  logic [8:0] app_wr_addr = 9'd0;
  logic [7:0] app_wr_data = 8'd0;
  logic       app_wr_en = 1'b0;
  logic       app_commit = 1'b0;
  logic [9:0] app_commit_len = 10'd0;
  logic       app_buf_free;
  logic       toggle_clear = 1'b0;
  logic       dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rdy;
    int         len;   // negative: length not checked
    logic [3:0] pid;
  } exp_t;
  exp_t sb_q[$];

  usb2_ep1_in dut (
    .phy_clk(phy_clk), .reset(reset), .xfer_in(xfer_in), .xfer_out(xfer_out),
    .xfer_pid(xfer_pid), .xfer_ready(xfer_ready), .data_pid(data_pid),
    .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
    .app_wr_addr(app_wr_addr), .app_wr_data(app_wr_data), .app_wr_en(app_wr_en),
    .app_commit(app_commit), .app_commit_len(app_commit_len),
    .app_buf_free(app_buf_free), .toggle_clear(toggle_clear), .dbg(dbg)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic tick();
    @(negedge phy_clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each IN window against the oldest queued expectation.
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge phy_clk);
      if (dbg && !prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_in", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("in_xfer_ready", int'(xfer_ready), int'(e.rdy));
          chk("in_data_pid", int'(data_pid), int'(e.pid));
          if (e.len >= 0) chk("in_buf_out_len", int'(buf_out_len), e.len);
        end
      end
      prev = dbg;
    end
  end

  task automatic write_pkt(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      app_wr_addr = 9'(i);
      app_wr_data = 8'(base + i);
      app_wr_en   = 1'b1;
      tick();
    end
    app_wr_en = 1'b0;
  endtask

  task automatic commit(input int len);
    app_commit     = 1'b1;
    app_commit_len = 10'(len);
    tick();
    app_commit = 1'b0;
  endtask

  // One IN transaction: rise, optional read check, fall with handshake hpid.
  task automatic in_xact(input logic [3:0] hpid, input logic exp_rdy, input int exp_len,
                         input logic [3:0] exp_pid, input int rd_addr, input int rd_exp,
                         input bit clr, input int coin_len);
    exp_t e;
    e.rdy = exp_rdy; e.len = exp_len; e.pid = exp_pid;
    sb_q.push_back(e);
    xfer_out = 1'b1;
    if (coin_len >= 0) begin
      app_commit     = 1'b1;
      app_commit_len = 10'(coin_len);
    end
    tick();
    app_commit = 1'b0;
    if (rd_addr >= 0) begin
      buf_out_addr = 9'(rd_addr);
      tick();
      chk("buf_out_q", int'(buf_out_q), rd_exp);
    end
    tick();
    xfer_pid = hpid;
    xfer_out = 1'b0;
    tick();
    toggle_clear = clr;
    tick();
    toggle_clear = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
  endtask

  initial begin
    tick(); tick();
    // Reset values while reset is held.
    chk("rst_xfer_ready", int'(xfer_ready), 0);
    chk("rst_app_buf_free", int'(app_buf_free), 1);
    chk("rst_data_pid", int'(data_pid), 'hC);
    chk("rst_buf_out_len", int'(buf_out_len), 0);
    chk("rst_buf_out_q", int'(buf_out_q), 0);
    chk("rst_dbg", int'(dbg), 0);
    reset = 1'b0;
    tick(); tick();

    // 64-byte packet, first attempt times out, retry is ACKed.
    write_pkt('h00, 64);
    commit(64);
    chk("free_after_commit", int'(app_buf_free), int'(DB));
    in_xact(4'h0, 1'b1, 64, 4'hC, 63, 'h3F, 1'b0, -1);
    chk("noack_free", int'(app_buf_free), int'(DB));
    chk("noack_pid", int'(data_pid), 'hC);
    in_xact(4'hD, 1'b1, 64, 4'hC, 5, 'h05, 1'b0, -1);
    chk("ack_free", int'(app_buf_free), 1);
    chk("ack_pid", int'(data_pid), 'h4);

    // Nothing committed: NAK, no toggle.
    in_xact(4'hD, 1'b0, -1, 4'h4, -1, 0, 1'b0, -1);
    chk("empty_pid", int'(data_pid), 'h4);

    // Commit coincident with the rising edge: NAK now, packet on next IN.
    write_pkt('h80, 4);
    in_xact(4'hD, 1'b0, -1, 4'h4, -1, 0, 1'b0, 4);
    chk("coin_free", int'(app_buf_free), int'(DB));
    chk("coin_pid", int'(data_pid), 'h4);
    in_xact(4'hD, 1'b1, 4, 4'h4, 2, 'h82, 1'b0, -1);
    chk("coin2_pid", int'(data_pid), 'hC);

    // Zero-length packet.
    commit(0);
    in_xact(4'hD, 1'b1, 0, 4'hC, -1, 0, 1'b0, -1);
    chk("zlp_pid", int'(data_pid), 'h4);

    // Reset in the middle of an IN window discards the packet.
    commit(16);
    begin
      exp_t e;
      e.rdy = 1'b1; e.len = 16; e.pid = 4'h4;
      sb_q.push_back(e);
    end
    xfer_out = 1'b1;
    tick(); tick();
    reset = 1'b1;
    xfer_out = 1'b0;
    tick();
    chk("midrst_xfer_ready", int'(xfer_ready), 0);
    chk("midrst_pid", int'(data_pid), 'hC);
    chk("midrst_free", int'(app_buf_free), 1);
    chk("midrst_dbg", int'(dbg), 0);
    reset = 1'b0;
    tick(); tick();
    in_xact(4'hD, 1'b0, -1, 4'hC, -1, 0, 1'b0, -1);

    // toggle_clear beats the ACK toggle.
    commit(8);
    in_xact(4'hD, 1'b1, 8, 4'hC, -1, 0, 1'b1, -1);
    chk("clr_pid", int'(data_pid), 'hC);
    chk("clr_free", int'(app_buf_free), 1);

    // Over-length commit is clamped.
    commit(600);
    in_xact(4'hD, 1'b1, 512, 4'hC, -1, 0, 1'b0, -1);
    chk("clamp_pid", int'(data_pid), 'h4);

`ifdef USB2_EP1_IN_DOUBLEBUF_EN
    // Ping-pong: two packets in flight, third commit ignored, FIFO order.
    do_reset();
    write_pkt('h10, 8);
    commit(8);
    chk("db_free1", int'(app_buf_free), 1);
    write_pkt('h20, 16);
    commit(16);
    chk("db_free2", int'(app_buf_free), 0);
    commit(4);
    in_xact(4'hD, 1'b1, 8, 4'hC, 3, 'h13, 1'b0, -1);
    chk("db_free3", int'(app_buf_free), 1);
    in_xact(4'hD, 1'b1, 16, 4'h4, 3, 'h23, 1'b0, -1);
    in_xact(4'hD, 1'b0, -1, 4'hC, -1, 0, 1'b0, -1);
    chk("db_free_end", int'(app_buf_free), 1);
`endif

    tick(); tick(); tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
